// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operand width,
// iteration count, operation codes and FSM state encoding.
package mul_div_unit_pkg;

    localparam int DATA_LEN = 32;
    localparam int MD_ITER  = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // MULT and DIV treat their operands as two's complement.
    function automatic logic md_is_signed(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    // Divide ops share the high opcode bit.
    function automatic logic md_is_div(input md_op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the pipeline control and the mul/div unit.
interface mul_div_unit_if;
    import mul_div_unit_pkg::*;

    logic                start;
    logic [1:0]          op;
    logic [DATA_LEN-1:0] src_a;
    logic [DATA_LEN-1:0] src_b;
    logic                hi_we;
    logic                lo_we;
    logic                busy;
    logic                done;
    logic                div_by_zero;
    logic [DATA_LEN-1:0] hi;
    logic [DATA_LEN-1:0] lo;

    modport master (
        output start, op, src_a, src_b, hi_we, lo_we,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, hi_we, lo_we,
        output busy, done, div_by_zero, hi, lo
    );

endinterface

// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit. Multiply (shift-add) and restoring
// divide share one 64-bit accumulator and one iteration counter; signed
// operations run on magnitudes and fix the signs when writing HI/LO.
module mul_div_unit
    import mul_div_unit_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    mul_div_unit_if.slave bus
);

    localparam int W = DATA_LEN;

    md_state_e      state_reg;
    logic [5:0]     count_reg;
    logic [2*W-1:0] acc_reg;      // {partial, multiplier} or {remainder, dividend/quotient}
    logic [W-1:0]   opnd_reg;     // multiplicand or divisor magnitude
    md_op_e         op_reg;
    logic           neg_q_reg;    // product / quotient must be negated
    logic           neg_r_reg;    // remainder must be negated (dividend was negative)
    logic           busy_reg;
    logic           done_reg;
    logic           dbz_reg;
    logic [W-1:0]   hi_reg;
    logic [W-1:0]   lo_reg;

    md_op_e         req_op;
    logic           req_signed;
    logic [W-1:0]   mag_a;
    logic [W-1:0]   mag_b;
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_step;
    logic [W:0]     div_trial;
    logic           div_ge;
    logic [W-1:0]   div_rem_sub;
    logic [2*W-1:0] div_step;
    logic [2*W-1:0] prod_final;
    logic [W-1:0]   quot_final;
    logic [W-1:0]   rem_final;
    logic [W-1:0]   hi_result;
    logic [W-1:0]   lo_result;

    // Operand magnitudes for the incoming request (most-negative value maps to itself, read as unsigned).
    always_comb begin
        req_op     = md_op_e'(bus.op);
        req_signed = md_is_signed(req_op);
        mag_a      = (req_signed && bus.src_a[W-1]) ? -bus.src_a : bus.src_a;
        mag_b      = (req_signed && bus.src_b[W-1]) ? -bus.src_b : bus.src_b;
    end

    // One shift-add multiply step and one restoring divide step on the shared accumulator.
    always_comb begin
        mul_sum     = {1'b0, acc_reg[2*W-1:W]} + {1'b0, opnd_reg};
        mul_step    = acc_reg[0] ? {mul_sum, acc_reg[W-1:1]} : {1'b0, acc_reg[2*W-1:1]};
        div_trial   = acc_reg[2*W-1:W-1];
        div_ge      = (div_trial >= {1'b0, opnd_reg});
        div_rem_sub = div_trial[W-1:0] - opnd_reg;
        div_step    = div_ge ? {div_rem_sub, acc_reg[W-2:0], 1'b1}
                             : {div_trial[W-1:0], acc_reg[W-2:0], 1'b0};
    end

    // Sign fix-up of the finished magnitudes and selection of the HI/LO write values.
    always_comb begin
        prod_final = neg_q_reg ? -acc_reg : acc_reg;
        quot_final = neg_q_reg ? -acc_reg[W-1:0] : acc_reg[W-1:0];
        rem_final  = neg_r_reg ? -acc_reg[2*W-1:W] : acc_reg[2*W-1:W];
        if (md_is_div(op_reg)) begin
            hi_result = rem_final;
            lo_result = quot_final;
        end else begin
            hi_result = prod_final[2*W-1:W];
            lo_result = prod_final[W-1:0];
        end
    end

    // Control FSM with the accumulator, counter and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
            acc_reg   <= '0;
            opnd_reg  <= '0;
            op_reg    <= MD_MULT;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            dbz_reg   <= 1'b0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        // Multiply keeps the multiplier in the low half; divide keeps the dividend there.
                        op_reg    <= req_op;
                        acc_reg   <= {{W{1'b0}}, md_is_div(req_op) ? mag_a : mag_b};
                        opnd_reg  <= md_is_div(req_op) ? mag_b : mag_a;
                        neg_q_reg <= req_signed && (bus.src_a[W-1] ^ bus.src_b[W-1]);
                        neg_r_reg <= req_signed && bus.src_a[W-1];
                        count_reg <= '0;
                        dbz_reg   <= 1'b0;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_RUN;
                    end else begin
                        if (bus.hi_we) hi_reg <= bus.src_a;
                        if (bus.lo_we) lo_reg <= bus.src_a;
                    end
                end
                ST_RUN: begin
                    if (md_is_div(op_reg) && (opnd_reg == '0)) begin
                        // Zero divisor: finish immediately, HI/LO untouched.
                        dbz_reg   <= 1'b1;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else if (count_reg == 6'(MD_ITER)) begin
                        hi_reg    <= hi_result;
                        lo_reg    <= lo_result;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else begin
                        acc_reg   <= md_is_div(op_reg) ? div_step : mul_step;
                        count_reg <= count_reg + 6'd1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.div_by_zero = dbz_reg;
    assign bus.hi          = hi_reg;
    assign bus.lo          = lo_reg;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: hand-computed HI/LO results, latency,
// divide-by-zero, busy-time masking and mid-operation reset.
module tb_mul_div_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   edges;
    int   extra_done;

    mul_div_unit_if md_if ();

    mul_div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (md_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present a request for one edge (E0); returns #1 after E0.
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        md_if.start = 1'b1;
        md_if.op    = op;
        md_if.src_a = a;
        md_if.src_b = b;
        @(posedge clk);
        #1;
        md_if.start = 1'b0;
        md_if.hi_we = 1'b0;
        md_if.lo_we = 1'b0;
    endtask

    // Count edges until done is seen (bounded).
    task automatic wait_done(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (md_if.done) break;
        end
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (md_if.done) n++;
        end
    endtask

    task automatic idle_write(input logic h, input logic l, input logic [31:0] a);
        md_if.hi_we = h;
        md_if.lo_we = l;
        md_if.src_a = a;
        @(posedge clk);
        #1;
        md_if.hi_we = 1'b0;
        md_if.lo_we = 1'b0;
    endtask

    initial begin
        md_if.start = 1'b0;
        md_if.op    = 2'd0;
        md_if.src_a = '0;
        md_if.src_b = '0;
        md_if.hi_we = 1'b0;
        md_if.lo_we = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(md_if.busy), 64'd0);
        chk("reset_done", 64'(md_if.done), 64'd0);
        chk("reset_dbz", 64'(md_if.div_by_zero), 64'd0);
        chk("reset_hilo", {md_if.hi, md_if.lo}, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // MULTU all-ones squared, 33-cycle latency
        start_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_busy_after_e0", 64'(md_if.busy), 64'd1);
        chk("multu_hilo_held", {md_if.hi, md_if.lo}, 64'd0);
        wait_done(edges);
        $display("MULTU ffffffff*ffffffff edges=%0d hi=%h lo=%h", edges, md_if.hi, md_if.lo);
        chk("multu_latency", 64'(edges), 64'd33);
        chk("multu_busy_at_done", 64'(md_if.busy), 64'd0);
        chk("multu_hilo", {md_if.hi, md_if.lo}, 64'hFFFF_FFFE_0000_0001);
        @(posedge clk);
        #1;
        chk("multu_done_one_cycle", 64'(md_if.done), 64'd0);

        // MULT -3*7 and MULTU of the same bits
        start_op(2'd0, 32'hFFFF_FFFD, 32'd7);
        wait_done(edges);
        $display("MULT -3*7 hi=%h lo=%h", md_if.hi, md_if.lo);
        chk("mult_neg_hilo", {md_if.hi, md_if.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        start_op(2'd1, 32'hFFFF_FFFD, 32'd7);
        wait_done(edges);
        $display("MULTU fffffffd*7 hi=%h lo=%h", md_if.hi, md_if.lo);
        chk("multu_hilo2", {md_if.hi, md_if.lo}, 64'h0000_0006_FFFF_FFEB);
        start_op(2'd0, 32'h8000_0000, 32'h8000_0000);
        wait_done(edges);
        $display("MULT 80000000*80000000 hi=%h lo=%h", md_if.hi, md_if.lo);
        chk("mult_minmin_hilo", {md_if.hi, md_if.lo}, 64'h4000_0000_0000_0000);

        // Divides
        start_op(2'd2, 32'hFFFF_FFF9, 32'd2);
        wait_done(edges);
        $display("DIV -7/2 edges=%0d hi=%h lo=%h", edges, md_if.hi, md_if.lo);
        chk("div_latency", 64'(edges), 64'd33);
        chk("div_neg_hilo", {md_if.hi, md_if.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        start_op(2'd2, 32'd7, 32'hFFFF_FFFE);
        wait_done(edges);
        $display("DIV 7/-2 hi=%h lo=%h", md_if.hi, md_if.lo);
        chk("div_negdivisor_hilo", {md_if.hi, md_if.lo}, 64'h0000_0001_FFFF_FFFD);
        // start wins over a simultaneous hi_we; HI must not change before done
        md_if.hi_we = 1'b1;
        start_op(2'd3, 32'd100, 32'd7);
        chk("start_priority_hi", 64'(md_if.hi), 64'h0000_0001);
        wait_done(edges);
        $display("DIVU 100/7 hi=%h lo=%h", md_if.hi, md_if.lo);
        chk("divu_hilo", {md_if.hi, md_if.lo}, 64'h0000_0002_0000_000E);
        start_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(edges);
        $display("DIV 80000000/-1 hi=%h lo=%h", md_if.hi, md_if.lo);
        chk("div_overflow_hilo", {md_if.hi, md_if.lo}, 64'h0000_0000_8000_0000);

        // MTHI/MTLO together, then separately, then divide by zero
        idle_write(1'b1, 1'b1, 32'h0000_A5A5);
        chk("mthi_mtlo_both", {md_if.hi, md_if.lo}, 64'h0000_A5A5_0000_A5A5);
        idle_write(1'b1, 1'b0, 32'd5);
        idle_write(1'b0, 1'b1, 32'd9);
        $display("MTHI 5 MTLO 9 hi=%h lo=%h", md_if.hi, md_if.lo);
        chk("mthi_mtlo_hilo", {md_if.hi, md_if.lo}, 64'h0000_0005_0000_0009);
        start_op(2'd3, 32'd3, 32'd0);
        wait_done(edges);
        $display("DIVU 3/0 edges=%0d dbz=%0d hi=%h lo=%h", edges, md_if.div_by_zero, md_if.hi, md_if.lo);
        chk("dbz_latency", 64'(edges), 64'd1);
        chk("dbz_flag", 64'(md_if.div_by_zero), 64'd1);
        chk("dbz_busy", 64'(md_if.busy), 64'd0);
        chk("dbz_hilo_unchanged", {md_if.hi, md_if.lo}, 64'h0000_0005_0000_0009);
        @(posedge clk);
        #1;
        chk("dbz_sticky", 64'(md_if.div_by_zero), 64'd1);

        // Requests during RUN are ignored
        start_op(2'd1, 32'd1234, 32'd5678);
        chk("dbz_cleared_on_start", 64'(md_if.div_by_zero), 64'd0);
        repeat (5) @(posedge clk);
        #1;
        md_if.start = 1'b1;
        md_if.op    = 2'd3;
        md_if.src_a = 32'hDEAD_BEEF;
        md_if.src_b = 32'd3;
        md_if.hi_we = 1'b1;
        md_if.lo_we = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        md_if.start = 1'b0;
        md_if.hi_we = 1'b0;
        md_if.lo_we = 1'b0;
        chk("busy_ignore_hilo_held", {md_if.hi, md_if.lo}, 64'h0000_0005_0000_0009);
        wait_done(edges);
        $display("MULTU 1234*5678 with busy pokes edges=%0d hi=%h lo=%h", 7 + edges, md_if.hi, md_if.lo);
        chk("busy_ignore_latency", 64'(7 + edges), 64'd33);
        chk("busy_ignore_hilo", {md_if.hi, md_if.lo}, 64'(32'd1234 * 32'd5678));
        count_done(40, extra_done);
        chk("busy_ignore_single_done", 64'(extra_done), 64'd0);

        // Reset in the middle of a MULT
        start_op(2'd0, 32'h0001_2345, 32'h0000_0777);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        $display("RST mid-MULT busy=%0d hi=%h lo=%h", md_if.busy, md_if.hi, md_if.lo);
        chk("rst_mid_busy", 64'(md_if.busy), 64'd0);
        chk("rst_mid_hilo", {md_if.hi, md_if.lo}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        count_done(40, extra_done);
        chk("rst_mid_no_done", 64'(extra_done), 64'd0);
        start_op(2'd3, 32'd9, 32'd3);
        wait_done(edges);
        $display("DIVU 9/3 edges=%0d hi=%h lo=%h", edges, md_if.hi, md_if.lo);
        chk("post_rst_latency", 64'(edges), 64'd33);
        chk("post_rst_divu_hilo", {md_if.hi, md_if.lo}, 64'h0000_0000_0000_0003);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
